// File: rtl/sd_cmd_responder.sv
// SD bus CMD-line card responder: deserialises 48-bit host commands and serialises card responses.
// Build option: define SD_CMD_CRC_CHECK_EN to discard commands whose received CRC7 does not match.
module sd_cmd_responder #(
    parameter int NCR = 2
) (
    input  logic        iclk,
    input  logic        irst,
    input  logic        ice,
    input  logic        icmd,
    output logic        ocmd,
    output logic        ocmd_oe,
    output logic [5:0]  oindex,
    output logic [31:0] oarg,
    output logic        ovalid,
    output logic        oerr,
    output logic        obusy,
    input  logic        iresp_start,
    input  logic        iresp_drop,
    input  logic [5:0]  iresp_index,
    input  logic [31:0] iresp_arg,
    input  logic        iresp_nocrc
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RX        = 3'd1;
    localparam logic [2:0] S_WAIT_RESP = 3'd2;
    localparam logic [2:0] S_WAIT_NCR  = 3'd3;
    localparam logic [2:0] S_TX        = 3'd4;

    localparam logic [5:0] LAST_BIT = 6'd47;
    localparam logic [5:0] LAST_HDR = 6'd39;
    localparam logic [5:0] LAST_CRC = 6'd46;
    localparam logic [5:0] NCR_LAST = 6'(NCR - 1);

    // One step of the serial CRC7 register, G(x) = x^7 + x^3 + 1.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb        = b ^ crc[6];
        crc7_step = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    endfunction

    logic [2:0]  r_state;
    logic [5:0]  r_bit_cnt;
    logic [5:0]  r_ncr_cnt;
    logic        r_ncr_done;
    logic [44:0] r_rx_sr;
    logic [38:0] r_tx_sr;
    logic [6:0]  r_tx_crc;
    logic        r_nocrc;
    logic        r_cmd;
    logic        r_cmd_oe;
    logic        r_valid;
    logic        r_err;
    logic [5:0]  r_index;
    logic [31:0] r_arg;

    logic [5:0]  w_bit_next;
    logic        w_tx_bit;
    logic        w_crc_bad;

    assign w_bit_next = r_bit_cnt + 6'd1;

    // NOTE: every path assigns w_tx_bit, so no latch is inferred.
    always_comb begin
        if (w_bit_next <= LAST_HDR)
            w_tx_bit = r_tx_sr[38];
        else if (w_bit_next <= LAST_CRC)
            w_tx_bit = r_nocrc | r_tx_crc[6];
        else
            w_tx_bit = 1'b1;
    end

`ifdef SD_CMD_CRC_CHECK_EN
    logic [6:0] r_rx_crc;

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst)
            r_rx_crc <= 7'd0;
        else if (r_state == S_IDLE)
            r_rx_crc <= 7'd0;
        else if (r_state == S_RX && ice && r_bit_cnt <= LAST_HDR)
            r_rx_crc <= crc7_step(r_rx_crc, icmd);
    end

    // Received CRC bits 40..46 sit in r_rx_sr[6:0] when the end bit arrives.
    assign w_crc_bad = (r_rx_sr[6:0] != r_rx_crc);
`else
    assign w_crc_bad = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments; all state resets asynchronously.
    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            r_state    <= S_IDLE;
            r_bit_cnt  <= 6'd0;
            r_ncr_cnt  <= 6'd0;
            r_ncr_done <= 1'b0;
            r_rx_sr    <= '0;
            r_tx_sr    <= '0;
            r_tx_crc   <= 7'd0;
            r_nocrc    <= 1'b0;
            r_cmd      <= 1'b1;
            r_cmd_oe   <= 1'b0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_index    <= 6'd0;
            r_arg      <= 32'd0;
        end else begin
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ice && !icmd) begin
                        r_state   <= S_RX;
                        r_bit_cnt <= 6'd1;
                        r_rx_sr   <= '0;
                    end
                end
                S_RX: begin
                    if (ice) begin
                        r_rx_sr   <= {r_rx_sr[43:0], icmd};
                        r_bit_cnt <= (r_bit_cnt == LAST_BIT) ? LAST_BIT : w_bit_next;
                        if (r_bit_cnt == 6'd1 && !icmd) begin
                            r_state <= S_IDLE;
                        end else if (r_bit_cnt == LAST_BIT) begin
                            if (!icmd || w_crc_bad) begin
                                r_err   <= 1'b1;
                                r_state <= S_IDLE;
                            end else begin
                                r_index <= r_rx_sr[44:39];
                                r_arg   <= r_rx_sr[38:7];
                                r_valid <= 1'b1;
                                r_state <= S_WAIT_RESP;
                            end
                        end
                    end
                end
                S_WAIT_RESP: begin
                    if (iresp_drop) begin
                        r_state <= S_IDLE;
                    end else if (iresp_start) begin
                        r_tx_sr    <= {1'b0, iresp_index, iresp_arg};
                        r_nocrc    <= iresp_nocrc;
                        r_tx_crc   <= 7'd0;
                        r_ncr_cnt  <= 6'd0;
                        r_ncr_done <= 1'b0;
                        r_state    <= S_WAIT_NCR;
                    end
                end
                S_WAIT_NCR: begin
                    if (ice) begin
                        if (r_ncr_done) begin
                            r_cmd_oe  <= 1'b1;
                            r_cmd     <= 1'b0;
                            r_bit_cnt <= 6'd0;
                            r_state   <= S_TX;
                        end else begin
                            r_ncr_cnt <= r_ncr_cnt + 6'd1;
                            if (r_ncr_cnt == NCR_LAST)
                                r_ncr_done <= 1'b1;
                        end
                    end
                end
                S_TX: begin
                    if (ice) begin
                        if (r_bit_cnt == LAST_BIT) begin
                            r_cmd_oe <= 1'b0;
                            r_cmd    <= 1'b1;
                            r_state  <= S_IDLE;
                        end else begin
                            r_bit_cnt <= w_bit_next;
                            r_cmd     <= w_tx_bit;
                            if (w_bit_next <= LAST_HDR) begin
                                r_tx_sr  <= {r_tx_sr[37:0], 1'b0};
                                r_tx_crc <= crc7_step(r_tx_crc, w_tx_bit);
                            end else begin
                                r_tx_crc <= {r_tx_crc[5:0], 1'b0};
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign ocmd    = r_cmd;
    assign ocmd_oe = r_cmd_oe;
    assign oindex  = r_index;
    assign oarg    = r_arg;
    assign ovalid  = r_valid;
    assign oerr    = r_err;
    assign obusy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_sd_cmd_responder.sv
// Self-checking bench for sd_cmd_responder: directed SD command/response cases plus randomized
// commands scored against a frame-level model (CRC7 by polynomial long division).
module tb_sd_cmd_responder;

    localparam int NCR = 2;
`ifdef SD_CMD_CRC_CHECK_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    logic        iclk = 1'b0;
    logic        irst = 1'b0;
    logic        ice = 1'b0;
    logic        icmd = 1'b1;
    logic        ocmd, ocmd_oe, ovalid, oerr, obusy;
    logic [5:0]  oindex;
    logic [31:0] oarg;
    logic        iresp_start = 1'b0;
    logic        iresp_drop = 1'b0;
    logic [5:0]  iresp_index = 6'd0;
    logic [31:0] iresp_arg = 32'd0;
    logic        iresp_nocrc = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic s_cmd, s_oe;

    int unsigned mon_valid = 0, mon_err = 0, mon_both = 0, mon_oe = 0;
    logic [5:0]  mon_index = 6'd0;
    logic [31:0] mon_arg = 32'd0;

    always #5 iclk = ~iclk;

    sd_cmd_responder #(.NCR(NCR)) dut (
        .iclk(iclk), .irst(irst), .ice(ice), .icmd(icmd),
        .ocmd(ocmd), .ocmd_oe(ocmd_oe), .oindex(oindex), .oarg(oarg),
        .ovalid(ovalid), .oerr(oerr), .obusy(obusy),
        .iresp_start(iresp_start), .iresp_drop(iresp_drop),
        .iresp_index(iresp_index), .iresp_arg(iresp_arg), .iresp_nocrc(iresp_nocrc)
    );

    always @(negedge iclk) begin
        if (ovalid === 1'b1) begin
            mon_valid++;
            mon_index = oindex;
            mon_arg   = oarg;
        end
        if (oerr === 1'b1) mon_err++;
        if (ovalid === 1'b1 && oerr === 1'b1) mon_both++;
        if (ocmd_oe === 1'b1) mon_oe++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // CRC7 as the remainder of d * x^7 divided by x^7 + x^3 + 1.
    function automatic logic [6:0] crc7(input logic [39:0] d);
        logic [46:0] r;
        logic [46:0] g;
        r = {d, 7'b0};
        for (int i = 46; i >= 7; i--) begin
            g = 47'h89 << (i - 7);
            if (r[i]) r = r ^ g;
        end
        return r[6:0];
    endfunction

    function automatic logic [47:0] make_frame(input logic tbit, input logic [5:0] idx,
                                               input logic [31:0] arg, input logic no_crc);
        logic [39:0] hdr;
        hdr = {1'b0, tbit, idx, arg};
        return {hdr, (no_crc ? 7'h7F : crc7(hdr)), 1'b1};
    endfunction

    // One SD clock period: four iclk cycles with ice high in the first; outputs sampled on the negedge after it.
    task automatic tick(input logic b);
        @(negedge iclk);
        ice  = 1'b1;
        icmd = b;
        @(negedge iclk);
        ice   = 1'b0;
        s_cmd = ocmd;
        s_oe  = ocmd_oe;
        repeat (2) @(negedge iclk);
    endtask

    task automatic send_bits(input logic [47:0] f, input int first, input int last);
        for (int i = first; i >= last; i--) tick(f[i]);
        icmd = 1'b1;
    endtask

    // Sends a host frame (only two bits if the transmission bit is 0) and scores the outcome.
    task automatic expect_cmd(input logic [47:0] f, input string tag, output bit exp_valid);
        int unsigned v0, e0;
        bit exp_err;
        v0 = mon_valid;
        e0 = mon_err;
        exp_valid = 1'b0;
        exp_err   = 1'b0;
        if (f[46] == 1'b0) begin
            send_bits(f, 47, 46);
            repeat (3) tick(1'b1);
        end else begin
            send_bits(f, 47, 0);
            if (f[0] == 1'b0) exp_err = 1'b1;
            else if (CRC_EN && f[7:1] != crc7(f[47:8])) exp_err = 1'b1;
            else exp_valid = 1'b1;
        end
        check({tag, "_valid"}, mon_valid - v0, exp_valid);
        check({tag, "_err"}, mon_err - e0, exp_err);
        check({tag, "_busy"}, obusy, exp_valid);
        if (exp_valid) begin
            check({tag, "_index"}, mon_index, f[45:40]);
            check({tag, "_arg"}, mon_arg, f[39:8]);
        end
    endtask

    task automatic pulse_resp(input logic st, input logic dr, input logic [5:0] idx,
                              input logic [31:0] arg, input logic nc);
        @(negedge iclk);
        iresp_start = st;
        iresp_drop  = dr;
        iresp_index = idx;
        iresp_arg   = arg;
        iresp_nocrc = nc;
        @(negedge iclk);
        iresp_start = 1'b0;
        iresp_drop  = 1'b0;
    endtask

    task automatic drop_and_check(input string tag);
        int unsigned oe0;
        oe0 = mon_oe;
        pulse_resp(1'b0, 1'b1, 6'd0, 32'd0, 1'b0);
        repeat (4) tick(1'b1);
        check({tag, "_drop_idle"}, obusy, 1'b0);
        check({tag, "_drop_no_oe"}, mon_oe - oe0, 0);
    endtask

    task automatic collect_resp(input logic [47:0] exp, input string tag);
        logic [47:0] got;
        int first;
        int n_oe;
        got   = '0;
        first = -1;
        n_oe  = 0;
        for (int t = 1; t <= NCR + 52; t++) begin
            tick(1'b1);
            if (s_oe) begin
                if (first < 0) first = t;
                got = {got[46:0], s_cmd};
                n_oe++;
            end
        end
        check({tag, "_latency"}, first, NCR + 1);
        check({tag, "_oe_len"}, n_oe, 48);
        check({tag, "_frame"}, got, exp);
        check({tag, "_release"}, {s_oe, s_cmd}, 2'b01);
        check({tag, "_idle"}, obusy, 1'b0);
    endtask

    initial begin
        bit v;
        int unsigned oe0, v0;
        logic [47:0] f;
        logic [5:0] ridx;
        logic [31:0] rarg;
        logic rnc;

        repeat (3) @(negedge iclk);
        check("rst_ocmd", ocmd, 1'b1);
        check("rst_oe", ocmd_oe, 1'b0);
        check("rst_index", oindex, 6'd0);
        check("rst_arg", oarg, 32'd0);
        check("rst_valid", ovalid, 1'b0);
        check("rst_err", oerr, 1'b0);
        check("rst_busy", obusy, 1'b0);
        irst = 1'b1;
        repeat (2) @(negedge iclk);

        // CMD0, dropped: the CMD line is never driven.
        oe0 = mon_oe;
        expect_cmd(48'h40_00000000_95, "cmd0", v);
        drop_and_check("cmd0");
        check("cmd0_never_oe", mon_oe - oe0, 0);

        // CMD8 with an R7-style echo.
        expect_cmd(48'h48_000001AA_87, "cmd8", v);
        pulse_resp(1'b1, 1'b0, 6'd8, 32'h000001AA, 1'b0);
        collect_resp(48'h08_000001AA_13, "cmd8_rsp");

        // R3-style response without CRC.
        expect_cmd(48'h48_000001AA_87, "cmd8b", v);
        pulse_resp(1'b1, 1'b0, 6'h3F, 32'h00FF8000, 1'b1);
        collect_resp(48'h3F_00FF8000_FF, "r3_rsp");

        // CMD17 with a flipped CRC bit; accepted only when the CRC checker is absent.
        expect_cmd(48'h51_00000000_55 ^ 48'h2, "cmd17_badcrc", v);
        if (v) begin
            check("cmd17_index17", mon_index, 6'd17);
            drop_and_check("cmd17");
        end

        expect_cmd(48'h51_00000000_54, "end0", v);
        expect_cmd(48'h11_00000000_55, "tbit0", v);

        // Reset asserted during TX bit 20.
        expect_cmd(48'h48_000001AA_87, "pre_rst", v);
        pulse_resp(1'b1, 1'b0, 6'd8, 32'h000001AA, 1'b0);
        repeat (NCR + 21) tick(1'b1);
        check("tx_bit20_oe", s_oe, 1'b1);
        @(negedge iclk);
        irst = 1'b0;
        #1;
        check("rst_tx_oe", ocmd_oe, 1'b0);
        check("rst_tx_cmd", ocmd, 1'b1);
        check("rst_tx_busy", obusy, 1'b0);
        @(negedge iclk);
        irst = 1'b1;
        expect_cmd(48'h48_000001AA_87, "post_rst", v);
        pulse_resp(1'b1, 1'b0, 6'd8, 32'h000001AA, 1'b0);
        collect_resp(48'h08_000001AA_13, "post_rst_rsp");

        // iresp_start in IDLE is ignored.
        oe0 = mon_oe;
        pulse_resp(1'b1, 1'b0, 6'd1, 32'h1, 1'b0);
        repeat (6) tick(1'b1);
        check("idle_start_busy", obusy, 1'b0);
        check("idle_start_no_oe", mon_oe - oe0, 0);

        // Start and drop together: drop wins.
        expect_cmd(48'h40_00000000_95, "both", v);
        oe0 = mon_oe;
        pulse_resp(1'b1, 1'b1, 6'd2, 32'h2, 1'b0);
        repeat (6) tick(1'b1);
        check("both_busy", obusy, 1'b0);
        check("both_no_oe", mon_oe - oe0, 0);

        // ice stalled for 100 iclk cycles mid-RX.
        f  = 48'h48_000001AA_87;
        v0 = mon_valid;
        send_bits(f, 47, 28);
        repeat (100) @(negedge iclk);
        check("freeze_busy", obusy, 1'b1);
        check("freeze_no_valid", mon_valid - v0, 0);
        send_bits(f, 27, 0);
        check("freeze_valid", mon_valid - v0, 1);
        check("freeze_index", mon_index, 6'd8);
        check("freeze_arg", mon_arg, 32'h000001AA);
        drop_and_check("freeze");

        // Randomized commands and responses.
        for (int n = 0; n < 24; n++) begin
            int kind;
            kind = $urandom_range(0, 3);
            f = make_frame(1'b1, 6'($urandom), $urandom, 1'b0);
            if (kind == 1) f[1 + $urandom_range(0, 6)] ^= 1'b1;
            if (kind == 2) f[0] = 1'b0;
            if (kind == 3) f[46] = 1'b0;
            expect_cmd(f, "rnd_cmd", v);
            if (v) begin
                if ($urandom_range(0, 1) == 0) begin
                    drop_and_check("rnd");
                end else begin
                    ridx = 6'($urandom);
                    rarg = $urandom;
                    rnc  = 1'($urandom_range(0, 1));
                    pulse_resp(1'b1, 1'b0, ridx, rarg, rnc);
                    collect_resp(make_frame(1'b0, ridx, rarg, rnc), "rnd_rsp");
                end
            end
        end

        check("valid_err_exclusive", mon_both, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
